// File: rtl/game_pkg.sv
// Shared constants for the game datapath: speed codes, scheduler states and
// the default frame-event line.
package game_pkg;

  localparam logic [1:0] SPD_HALT = 2'd0;
  localparam logic [1:0] SPD_SLOW = 2'd1;
  localparam logic [1:0] SPD_MED  = 2'd2;
  localparam logic [1:0] SPD_FAST = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BALL   = 2'd1,
    S_PLAYER = 2'd2,
    S_ENEMY  = 2'd3
  } sched_state_t;

  localparam int FRAME_LINE_DEFAULT = 480;

  // Frames per move for a speed code; 0 means the object never moves.
  function automatic logic [4:0] speed_period(input logic [1:0] code,
                                              input int slow_p,
                                              input int med_p);
    logic [4:0] p;
    case (code)
      SPD_SLOW: p = 5'(slow_p);
      SPD_MED:  p = 5'(med_p);
      SPD_FAST: p = 5'd1;
      default:  p = 5'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Per-object frame divider: counts honoured frame events and flags the ones
// on which the object should take a one-pixel step.
module rate_divider
  import game_pkg::*;
#(
  parameter int SLOW_PERIOD = 4,
  parameter int MED_PERIOD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       fire,
  output logic [3:0] cnt
);

  logic [4:0] period;

  always_comb begin
    period = speed_period(speed, SLOW_PERIOD, MED_PERIOD);
    fire   = (period != 5'd0) && ({1'b0, cnt} >= (period - 5'd1));
  end

  // A halted object keeps its count so resuming picks up where it left off.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (en && (period != 5'd0)) begin
      cnt <= fire ? 4'd0 : cnt + 4'd1;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Once-per-frame move scheduler: at the blanking frame event it advances the
// three object dividers and then plays out ball/player/enemy strobe slots.
//
// state    | meaning
// S_IDLE   | waiting for a frame event
// S_BALL   | ball slot, strobe on the next pixpulse
// S_PLAYER | player paddle slot
// S_ENEMY  | enemy paddle slot
module move_scheduler
  import game_pkg::*;
#(
  parameter int FRAME_LINE  = FRAME_LINE_DEFAULT,
  parameter int SLOW_PERIOD = 4,
  parameter int MED_PERIOD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       pause,
  input  logic [1:0] ball_speed,
  input  logic [1:0] player_speed,
  input  logic [1:0] enemy_speed,
  output logic       move_ball,
  output logic       move_player,
  output logic       move_enemy,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  sched_state_t state, state_nxt;

  logic       frame_evt;
  logic       go;
  logic       fire_ball_d, fire_player_d, fire_enemy_d;
  logic       fire_ball_q, fire_player_q, fire_enemy_q;
  logic [3:0] cnt_ball, cnt_player, cnt_enemy;

  assign frame_evt = pixpulse && (hcount == 10'd0) && (vcount == 10'(FRAME_LINE));
  assign go        = frame_evt && (state == S_IDLE) && !pause;

  rate_divider #(.SLOW_PERIOD(SLOW_PERIOD), .MED_PERIOD(MED_PERIOD)) u_div_ball (
    .clk   (clk),
    .rst   (rst),
    .en    (go),
    .speed (ball_speed),
    .fire  (fire_ball_d),
    .cnt   (cnt_ball)
  );

  rate_divider #(.SLOW_PERIOD(SLOW_PERIOD), .MED_PERIOD(MED_PERIOD)) u_div_player (
    .clk   (clk),
    .rst   (rst),
    .en    (go),
    .speed (player_speed),
    .fire  (fire_player_d),
    .cnt   (cnt_player)
  );

  rate_divider #(.SLOW_PERIOD(SLOW_PERIOD), .MED_PERIOD(MED_PERIOD)) u_div_enemy (
    .clk   (clk),
    .rst   (rst),
    .en    (go),
    .speed (enemy_speed),
    .fire  (fire_enemy_d),
    .cnt   (cnt_enemy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      fire_ball_q   <= 1'b0;
      fire_player_q <= 1'b0;
      fire_enemy_q  <= 1'b0;
      frame_cnt     <= 8'd0;
    end else begin
      state <= state_nxt;
      if (go) begin
        fire_ball_q   <= fire_ball_d;
        fire_player_q <= fire_player_d;
        fire_enemy_q  <= fire_enemy_d;
      end
      if (frame_evt) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Every slot is consumed on its pixpulse whether or not the object fires.
  always_comb begin
    state_nxt   = state;
    move_ball   = 1'b0;
    move_player = 1'b0;
    move_enemy  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_BALL;
      end
      S_BALL: begin
        move_ball = fire_ball_q && pixpulse && !rst;
        if (pixpulse) state_nxt = S_PLAYER;
      end
      S_PLAYER: begin
        move_player = fire_player_q && pixpulse && !rst;
        if (pixpulse) state_nxt = S_ENEMY;
      end
      S_ENEMY: begin
        move_enemy = fire_enemy_q && pixpulse && !rst;
        if (pixpulse) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Divider counts are kept for debug visibility only.
  logic unused_cnt;
  assign unused_cnt = ^{cnt_ball, cnt_player, cnt_enemy};

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: frame sequences, speed patterns, pause,
// mid-sequence reset and frame-event boundary cases.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pixpulse = 1'b0;
  logic [9:0] hcount = 10'd5;
  logic [9:0] vcount = 10'd100;
  logic       pause = 1'b0;
  logic [1:0] ball_speed = 2'd3;
  logic [1:0] player_speed = 2'd3;
  logic [1:0] enemy_speed = 2'd3;
  logic       move_ball, move_player, move_enemy, busy;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int ph = 0;
  logic [7:0] fcnt = 8'd0;

  localparam logic [16:0] BUSY_MASK = 17'h1FFE;
  localparam logic [16:0] BALL_MASK = 17'h00010;
  localparam logic [16:0] PLYR_MASK = 17'h00100;
  localparam logic [16:0] ENMY_MASK = 17'h01000;

  always #5 clk = ~clk;

  move_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .pixpulse     (pixpulse),
    .hcount       (hcount),
    .vcount       (vcount),
    .pause        (pause),
    .ball_speed   (ball_speed),
    .player_speed (player_speed),
    .enemy_speed  (enemy_speed),
    .move_ball    (move_ball),
    .move_player  (move_player),
    .move_enemy   (move_enemy),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clk; inputs for the new cycle are applied 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
    pixpulse = (ph == 0);
  endtask

  task automatic align_pix();
    int guard = 0;
    next_cycle();
    while (!pixpulse && guard < 8) begin
      next_cycle();
      guard++;
    end
    check("align", {31'd0, pixpulse}, 32'd1);
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    #1;
    check("rst_moves", {29'd0, move_ball, move_player, move_enemy}, 32'd0);
    next_cycle();
    rst = 1'b0;
    fcnt = 8'd0;
  endtask

  task automatic frame(input string tag, input logic eb, input logic ep,
                       input logic ee, input logic pz);
    logic [16:0] vb, vp, ve, vbusy;
    vb = '0; vp = '0; ve = '0; vbusy = '0;
    align_pix();
    hcount = 10'd0;
    vcount = 10'd480;
    pause  = pz;
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      hcount = 10'd5;
      vcount = 10'd481;
      #1;
      vb[k] = move_ball; vp[k] = move_player; ve[k] = move_enemy; vbusy[k] = busy;
    end
    pause = 1'b0;
    fcnt = fcnt + 8'd1;
    check({tag, "_ball"},   {15'd0, vb},    {15'd0, eb ? BALL_MASK : 17'd0});
    check({tag, "_player"}, {15'd0, vp},    {15'd0, ep ? PLYR_MASK : 17'd0});
    check({tag, "_enemy"},  {15'd0, ve},    {15'd0, ee ? ENMY_MASK : 17'd0});
    check({tag, "_busy"},   {15'd0, vbusy}, {15'd0, pz ? 17'd0 : BUSY_MASK});
    check({tag, "_fcnt"},   {24'd0, frame_cnt}, {24'd0, fcnt});
  endtask

  task automatic quick_paused_event();
    align_pix();
    hcount = 10'd0;
    vcount = 10'd480;
    pause  = 1'b1;
    next_cycle();
    hcount = 10'd5;
    vcount = 10'd481;
    pause  = 1'b0;
    fcnt = fcnt + 8'd1;
  endtask

  initial begin
    logic [16:0] vb, vp, ve, vbusy;

    do_reset();
    #1;
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_fcnt",  {24'd0, frame_cnt}, 32'd0);
    check("reset_moves", {29'd0, move_ball, move_player, move_enemy}, 32'd0);

    // all fast
    for (int i = 1; i <= 4; i++) frame("fast", 1'b1, 1'b1, 1'b1, 1'b0);

    // ball slow, player halted, enemy medium
    do_reset();
    ball_speed = 2'd1; player_speed = 2'd0; enemy_speed = 2'd2;
    for (int i = 1; i <= 8; i++)
      frame("mixed", (i % 4) == 0, 1'b0, (i % 2) == 0, 1'b0);

    // pause on events 3-5
    do_reset();
    ball_speed = 2'd3; player_speed = 2'd3; enemy_speed = 2'd3;
    for (int i = 1; i <= 6; i++) begin
      logic pz;
      pz = (i >= 3) && (i <= 5);
      frame("pause", !pz, !pz, !pz, pz);
    end

    // reset in the player slot
    do_reset();
    frame("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
    vb = '0; vp = '0; ve = '0; vbusy = '0;
    align_pix();
    hcount = 10'd0;
    vcount = 10'd480;
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      hcount = 10'd5;
      vcount = 10'd481;
      rst = (k == 6);
      #1;
      vb[k] = move_ball; vp[k] = move_player; ve[k] = move_enemy; vbusy[k] = busy;
    end
    fcnt = 8'd0;
    check("midrst_ball",   {15'd0, vb}, {15'd0, BALL_MASK});
    check("midrst_player", {15'd0, vp}, 32'd0);
    check("midrst_enemy",  {15'd0, ve}, 32'd0);
    check("midrst_busy",   {15'd0, vbusy}, 32'h7E);
    check("midrst_fcnt",   {24'd0, frame_cnt}, 32'd0);
    frame("post_rst", 1'b1, 1'b1, 1'b1, 1'b0);

    // slow ball builds cnt=3 then switches to fast
    do_reset();
    ball_speed = 2'd1; player_speed = 2'd0; enemy_speed = 2'd0;
    for (int i = 1; i <= 3; i++) frame("slow_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    ball_speed = 2'd3;
    for (int i = 4; i <= 6; i++) frame("to_fast", 1'b1, 1'b0, 1'b0, 1'b0);

    // event line without pixpulse
    align_pix();
    next_cycle();
    hcount = 10'd0;
    vcount = 10'd480;
    next_cycle();
    next_cycle();
    hcount = 10'd5;
    vcount = 10'd481;
    vbusy = '0;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      #1;
      vbusy[k] = busy;
    end
    check("nopix_busy", {15'd0, vbusy}, 32'd0);
    check("nopix_fcnt", {24'd0, frame_cnt}, {24'd0, fcnt});

    // line 479 with pixpulse
    align_pix();
    hcount = 10'd0;
    vcount = 10'd479;
    vbusy = '0;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      hcount = 10'd5;
      vcount = 10'd481;
      #1;
      vbusy[k] = busy;
    end
    check("line479_busy", {15'd0, vbusy}, 32'd0);
    check("line479_fcnt", {24'd0, frame_cnt}, {24'd0, fcnt});

    // frame_cnt wrap
    do_reset();
    for (int i = 0; i < 255; i++) quick_paused_event();
    #1;
    check("wrap_255", {24'd0, frame_cnt}, 32'd255);
    quick_paused_event();
    #1;
    check("wrap_0",    {24'd0, frame_cnt}, 32'd0);
    check("wrap_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Frame-synchronous move-pulse scheduler for the game's moving objects: ball, player paddle and enemy paddle. Once per video frame, at the start of vertical blanking, it advances a per-object frame-rate divider. It then issues that object's one-pixel-step `move` strobe in a fixed, staggered slot order. Sits between the VGA timing generator (hcount/vcount/pixpulse) and the three object blocks, whose `move` inputs it drives; all updates happen after the visible-area neighbour scan completes.

## Interface
Parameters:
- FRAME_LINE, 480: vcount value whose hcount==0 pixel is the frame event.
- SLOW_PERIOD, 4: frames per move at speed code 1 (range 1..16).
- MED_PERIOD, 2: frames per move at speed code 2 (range 1..16).

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- pixpulse  in  1  one-clk strobe every 4 clks (25 MHz pixel rate).
- hcount  in  10  current pixel x.
- vcount  in  10  current pixel y.
- pause  in  1  freeze all motion, sampled at frame event.
- ball_speed  in  2  speed code for ball.
- player_speed  in  2  speed code for player paddle.
- enemy_speed  in  2  speed code for enemy paddle.
- move_ball  out  1  ball move strobe.
- move_player  out  1  player paddle move strobe.
- move_enemy  out  1  enemy paddle move strobe.
- busy  out  1  sequence in progress (state != IDLE).
- frame_cnt  out  8  frame events since reset, wraps.

## Operation
- Frame event: pixpulse & hcount==0 & vcount==FRAME_LINE. It is honoured only in IDLE and ignored otherwise.
- Speed code maps to period P: 0 halted (no moves), 1 SLOW_PERIOD, 2 MED_PERIOD, 3 period 1 (every frame).
- Each object has a 4-bit frame counter `cnt`.
- Counter update at a frame event with pause=0:
  - P==0: cnt held, fire=0.
  - P!=0 and cnt >= P-1: fire=1, cnt<=0.
  - Otherwise: fire=0, cnt<=cnt+1.
- Speed inputs are sampled at the frame event only. A speed change therefore takes effect at the very next event, using the current cnt.
- Fire flags are latched per object.
- FSM states: IDLE -> BALL -> PLAYER -> ENEMY -> IDLE.
  - IDLE -> BALL on a frame event with pause=0.
  - Each later transition occurs on a pixpulse cycle.
- Slots are fixed: every slot is consumed even when its fire flag is 0.
- Strobes: move_x = (state==X) & fire_x & pixpulse & ~rst.
  - Each strobe is exactly one clk wide and coincides with a pixpulse cycle, so object blocks sample it.
  - The neighbour-clear cycle in each object block follows it.
- Frame event with pause=1:
  - cnt and fire unchanged; state stays IDLE; no strobes.
  - frame_cnt still increments.
- frame_cnt increments on every frame event, paused or not, and wraps 255->0.

## Timing
- Event at pixpulse clk E: state=BALL from E+1.
- move_ball high at clk E+4, move_player at E+8, move_enemy at E+12. State=IDLE from E+13.
- busy high E+1..E+12 (12 clks).
- Sequence ends well before vcount wraps to 0, so no strobe ever occurs during the visible area.
- Reset values: state IDLE, all cnt 0, fire flags 0, frame_cnt 0, busy 0, all move_* 0.
- move_* are forced low in any clk where rst=1. This includes reset mid-sequence: remaining slots are dropped, with no pending strobe after release.
- First moves after reset: speed 3 fires at the 1st event, speed 2 (P=2) at the 2nd, speed 1 (P=4) at the 4th.

## Structure
- Shared package `game_pkg`:
  - speed code constants SPD_HALT/SPD_SLOW/SPD_MED/SPD_FAST;
  - FSM state encoding S_IDLE/S_BALL/S_PLAYER/S_ENEMY;
  - FRAME_LINE default 480.
- One sub-module `rate_divider`:
  - inputs: speed code, period params, frame-event enable;
  - outputs: fire, plus its cnt;
  - instantiated three times.
- The top holds the FSM, fire latches, frame_cnt and strobe gating.

## Test plan
- All speeds 3, pause 0, 4 frame events:
  - each frame, move_ball at E+4, move_player at E+8, move_enemy at E+12, each 1 clk wide;
  - busy high 12 clks;
  - frame_cnt 0->4.
- ball_speed 1, enemy_speed 2, player_speed 0, 8 events:
  - move_ball on events 4 and 8;
  - move_enemy on events 2, 4, 6, 8;
  - move_player never;
  - busy still 12 clks every frame.
- Speeds 3, pause=1 on events 3-5:
  - no strobes and busy stays 0 on those frames;
  - frame_cnt still advances to 5;
  - moves resume on event 6.
- rst asserted at E+6 (PLAYER slot, speeds 3):
  - move_player and move_enemy never assert that frame;
  - busy 0 and frame_cnt 0 after the edge;
  - next event after release sequences normally.
- ball_speed 1 for 3 events (cnt=3), then set 3 before event 4: move_ball fires on event 4, then every frame.
- Boundary cases:
  - hcount==0, vcount==480 with pixpulse=0 produces no event;
  - vcount==479 produces no event;
  - 256 events wrap frame_cnt to 0.
